// File: rtl/phoneme_sequencer.sv
// Queues phoneme codes and plays them one at a time through phoneme_to_address, with a tick-counted
// silence gap between phonemes and a watchdog that abandons a read whose done never arrives.
module phoneme_sequencer #(
   parameter int DEPTH     = 16,
   parameter int PTR_W     = 4,
   parameter int GAP_TICKS = 4,
   parameter int TIMEOUT   = 1048576
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic [7:0]       wr_data,
   input  logic             play,
   input  logic             abort,
   input  logic             tick,
   input  logic             done,
   output logic [7:0]       phoneme_sel,
   output logic             start,
   output logic             busy,
   output logic             fifo_full,
   output logic [PTR_W:0]   fifo_count,
   output logic             overflow,
   output logic             timeout_err,
   output logic [15:0]      phonemes_played,
   output logic [2:0]       state
);

   localparam int WD_W  = $clog2(TIMEOUT) + 1;
   localparam int GAP_W = $clog2(GAP_TICKS + 1) + 1;
   localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);
   localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);
   localparam logic [GAP_W-1:0] GAP_INIT = GAP_W'(GAP_TICKS);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_POP   = 3'd1,
      S_START = 3'd2,
      S_WAIT  = 3'd3,
      S_GAP   = 3'd4
   } state_t;

   state_t           state_q;
   logic [7:0]       mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [PTR_W:0]   count_q;
   logic [7:0]       sel_q;
   logic             start_q, overflow_q, timeout_q, tick_q;
   logic [15:0]      played_q;
   logic [WD_W-1:0]  wd_q;
   logic [GAP_W-1:0] gap_q;

   logic full, push, pop, tick_rise, launch;

   // Fullness uses the pre-cycle count, so a push into a full FIFO is dropped even if a pop happens too.
   assign full      = (count_q == FULL_CNT);
   assign push      = wr_en && !full && !abort;
   assign pop       = (state_q == S_POP) && !abort;
   assign tick_rise = tick && !tick_q;
   assign launch    = play && (count_q != '0);

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= wr_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         sel_q      <= '0;
         start_q    <= 1'b0;
         overflow_q <= 1'b0;
         timeout_q  <= 1'b0;
         tick_q     <= 1'b0;
         played_q   <= '0;
         wd_q       <= '0;
         gap_q      <= '0;
      end else begin
         tick_q <= tick;
         if (abort) begin
            // A downstream read already in flight is left alone; its done lands in IDLE and is ignored.
            state_q    <= S_IDLE;
            start_q    <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            timeout_q  <= 1'b0;
         end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            if (wr_en && full) overflow_q <= 1'b1;
            case ({push, pop})
               2'b10:   count_q <= count_q + 1'b1;
               2'b01:   count_q <= count_q - 1'b1;
               default: count_q <= count_q;
            endcase

            start_q <= 1'b0;
            case (state_q)
               S_IDLE: begin
                  if (launch) state_q <= S_POP;
               end
               S_POP: begin
                  sel_q   <= mem_q[rd_ptr_q];
                  start_q <= 1'b1;
                  state_q <= S_START;
               end
               S_START: begin
                  wd_q    <= '0;
                  state_q <= S_WAIT;
               end
               S_WAIT: begin
                  if (done) begin
                     played_q <= played_q + 1'b1;
                     if (GAP_TICKS == 0) begin
                        state_q <= launch ? S_POP : S_IDLE;
                     end else begin
                        gap_q   <= GAP_INIT;
                        state_q <= S_GAP;
                     end
                  end else if (wd_q + 1'b1 == WD_LAST) begin
                     // The start cycle counts toward the budget: the error shows TIMEOUT cycles after start.
                     timeout_q <= 1'b1;
                     state_q   <= S_IDLE;
                  end else begin
                     wd_q <= wd_q + 1'b1;
                  end
               end
               S_GAP: begin
                  if (gap_q == '0) begin
                     state_q <= launch ? S_POP : S_IDLE;
                  end else if (tick_rise) begin
                     gap_q <= gap_q - 1'b1;
                  end
               end
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

   assign phoneme_sel     = sel_q;
   assign start           = start_q;
   assign busy            = (state_q != S_IDLE);
   assign fifo_full       = full;
   assign fifo_count      = count_q;
   assign overflow        = overflow_q;
   assign timeout_err     = timeout_q;
   assign phonemes_played = played_q;
   assign state           = state_q;

endmodule

// File: tb/tb_phoneme_sequencer.sv
// Directed bench for phoneme_sequencer: playback order, gap length, FIFO limits, watchdog, abort and reset.
module tb_phoneme_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        wr_en = 1'b0;
   logic [7:0]  wr_data = '0;
   logic        play = 1'b0;
   logic        abort = 1'b0;
   logic        tick = 1'b0;
   logic        done = 1'b0;
   logic [7:0]  phoneme_sel;
   logic        start, busy, fifo_full, overflow, timeout_err;
   logic [4:0]  fifo_count;
   logic [15:0] phonemes_played;
   logic [2:0]  state;

   int checks = 0;
   int errors = 0;
   int tick_rises = 0;
   logic tick_prev = 1'b0;
   int r0;

   phoneme_sequencer #(.DEPTH(16), .PTR_W(4), .GAP_TICKS(4), .TIMEOUT(64)) dut (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .play(play), .abort(abort),
      .tick(tick), .done(done), .phoneme_sel(phoneme_sel), .start(start), .busy(busy),
      .fifo_full(fifo_full), .fifo_count(fifo_count), .overflow(overflow),
      .timeout_err(timeout_err), .phonemes_played(phonemes_played), .state(state)
   );

   always #5 clk = ~clk;

   always begin
      repeat (4) @(negedge clk);
      tick = ~tick;
   end

   always @(posedge clk) begin
      if (tick && !tick_prev) tick_rises++;
      tick_prev = tick;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish, errors=%0d", errors);
      $fatal(1);
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic push(input logic [7:0] d);
      wr_en = 1'b1;
      wr_data = d;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic pulse_done();
      done = 1'b1;
      @(negedge clk);
      done = 1'b0;
   endtask

   task automatic wait_start(input string tag, input int max);
      int n = 0;
      while (start !== 1'b1 && n < max) begin
         @(negedge clk);
         n++;
      end
      check_eq(tag, start, 1);
   endtask

   task automatic wait_state(input string tag, input logic [2:0] tgt, input int max);
      int n = 0;
      while (state !== tgt && n < max) begin
         @(negedge clk);
         n++;
      end
      check_eq(tag, state, tgt);
   endtask

   initial begin
      // Reset values
      repeat (2) @(negedge clk);
      check_eq("rst_state", state, 0);
      check_eq("rst_count", fifo_count, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_start", start, 0);
      check_eq("rst_sel", phoneme_sel, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Two phonemes, gap of four tick edges
      push(8'h09);
      push(8'h0A);
      check_eq("t1_count", fifo_count, 2);
      play = 1'b1;
      @(negedge clk);
      check_eq("t1_pop_state", state, 1);
      check_eq("t1_pop_start", start, 0);
      @(negedge clk);
      check_eq("t1_start1", start, 1);
      check_eq("t1_start_state", state, 2);
      check_eq("t1_sel1", phoneme_sel, 8'h09);
      @(negedge clk);
      check_eq("t1_start_once", start, 0);
      repeat (19) @(negedge clk);
      pulse_done();
      check_eq("t1_gap_state", state, 4);
      check_eq("t1_played1", phonemes_played, 1);
      r0 = tick_rises;
      wait_start("t1_start2", 100);
      check_eq("t1_gap_ticks", tick_rises - r0, 4);
      check_eq("t1_sel2", phoneme_sel, 8'h0A);
      repeat (20) @(negedge clk);
      check_eq("t1_sel_hold", phoneme_sel, 8'h0A);
      pulse_done();
      wait_state("t1_idle", 0, 100);
      check_eq("t1_played2", phonemes_played, 2);
      check_eq("t1_busy", busy, 0);
      play = 1'b0;

      // 17 writes into a 16-deep FIFO, then full playback in order
      for (int i = 0; i < 17; i++) push(8'h20 + 8'(i));
      check_eq("t2_count", fifo_count, 16);
      check_eq("t2_full", fifo_full, 1);
      check_eq("t2_overflow", overflow, 1);
      play = 1'b1;
      for (int i = 0; i < 16; i++) begin
         wait_start($sformatf("t2_start%0d", i), 100);
         check_eq($sformatf("t2_sel%0d", i), phoneme_sel, 8'h20 + 8'(i));
         repeat (3) @(negedge clk);
         pulse_done();
      end
      wait_state("t2_idle", 0, 100);
      check_eq("t2_played", phonemes_played, 18);
      check_eq("t2_empty", fifo_count, 0);
      check_eq("t2_ovf_sticky", overflow, 1);

      // Watchdog: no done after start
      push(8'h55);
      wait_start("t4_start", 20);
      for (int k = 1; k <= 64; k++) begin
         @(negedge clk);
         if (k == 63) begin
            check_eq("t4_err_early", timeout_err, 0);
            check_eq("t4_wait_state", state, 3);
         end
         if (k == 64) begin
            check_eq("t4_err", timeout_err, 1);
            check_eq("t4_idle", state, 0);
            check_eq("t4_busy", busy, 0);
         end
      end
      pulse_done();
      check_eq("t4_late_done", phonemes_played, 18);
      check_eq("t4_late_state", state, 0);
      push(8'h66);
      wait_start("t4_replay", 20);
      check_eq("t4_replay_sel", phoneme_sel, 8'h66);
      repeat (3) @(negedge clk);
      pulse_done();
      wait_state("t4_replay_idle", 0, 100);
      check_eq("t4_err_sticky", timeout_err, 1);
      check_eq("t4_played", phonemes_played, 19);

      // Push and pop in the same cycle
      play = 1'b0;
      for (int i = 0; i < 4; i++) push(8'h31 + 8'(i));
      play = 1'b1;
      wait_start("t3_start", 20);
      check_eq("t3_sel1", phoneme_sel, 8'h31);
      check_eq("t3_count3", fifo_count, 3);
      repeat (3) @(negedge clk);
      pulse_done();
      wait_state("t3_pop", 1, 100);
      check_eq("t3_pre_count", fifo_count, 3);
      push(8'h35);
      check_eq("t3_pushpop_count", fifo_count, 3);
      check_eq("t3_sel2", phoneme_sel, 8'h32);
      push(8'h36);
      push(8'h37);
      check_eq("t3_count5", fifo_count, 5);
      pulse_done();
      check_eq("t5_gap_state", state, 4);

      // Abort during gap, with a concurrent write
      abort = 1'b1;
      wr_en = 1'b1;
      wr_data = 8'h99;
      @(negedge clk);
      abort = 1'b0;
      wr_en = 1'b0;
      check_eq("t5_state", state, 0);
      check_eq("t5_count", fifo_count, 0);
      check_eq("t5_busy", busy, 0);
      check_eq("t5_start", start, 0);
      check_eq("t5_ovf_clr", overflow, 0);
      check_eq("t5_err_clr", timeout_err, 0);
      check_eq("t5_played", phonemes_played, 21);
      repeat (5) @(negedge clk);
      pulse_done();
      check_eq("t5_late_state", state, 0);
      check_eq("t5_late_played", phonemes_played, 21);
      play = 1'b0;

      // Asynchronous reset while waiting for done
      push(8'h42);
      play = 1'b1;
      wait_start("t6_start", 20);
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check_eq("t6_state", state, 0);
      check_eq("t6_sel", phoneme_sel, 0);
      check_eq("t6_busy", busy, 0);
      check_eq("t6_count", fifo_count, 0);
      check_eq("t6_played", phonemes_played, 0);
      check_eq("t6_start", start, 0);
      play = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_eq("t6_post_state", state, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
